// File: rtl/seq_detect_scheduler_if.sv
// Requester-side bus of seq_detect_scheduler: frame requests in, grants and results out.
// Ports: req/frame_data (requester -> scheduler), gnt (one-hot accept pulse),
//        busy, done/done_id/hit_count (scheduler -> requester).
interface seq_detect_scheduler_if #(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*FRAME_W-1:0] frame_data;
  logic [N_REQ-1:0]         gnt;
  logic                     busy;
  logic                     done;
  logic [ID_W-1:0]          done_id;
  logic [CNT_W-1:0]         hit_count;

  // Requester side.
  modport master (
    output req, frame_data,
    input  gnt, busy, done, done_id, hit_count
  );

  // Scheduler side.
  modport slave (
    input  req, frame_data,
    output gnt, busy, done, done_id, hit_count
  );
endinterface

// File: rtl/seq_detect_scheduler.sv
// Purpose: round-robin share of one serial sequence detector; shifts each frame MSB-first, counts hits.
// Latency: gnt one cycle after req is seen in IDLE, done FRAME_W+3 cycles after req; FRAME_W+4 cycles/frame.
// Backpressure: requesters hold req and frame_data until gnt; requests are only sampled in IDLE.
// Ports: clk, reset (sync, active-high); bus (slave modport: req, frame_data, gnt, busy, done,
//        done_id, hit_count); det_reset/det_in_bit drive the detector, det_seq_detected is its output.
module seq_detect_scheduler #(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_detect_scheduler_if.slave bus,
  output logic                  det_reset,
  output logic                  det_in_bit,
  input  logic                  det_seq_detected
);

  localparam int BC_W = $clog2(FRAME_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] sreg;
  logic [BC_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]   hits, hits_nxt;
  logic [ID_W-1:0]    cur_id, last_id;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic               sample_en;
  int                 idx;

  // Round-robin pick: scan last_id+1, last_id+2, ... The loop runs from the
  // farthest offset down so the nearest requester is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(last_id) + off) % N_REQ;
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  // Next state and detector-facing outputs.
  always_comb begin
    state_nxt  = state;
    det_reset  = reset;
    det_in_bit = 1'b0;
    sample_en  = 1'b0;
    unique case (state)
      IDLE:  if (win_vld) state_nxt = CLEAR;
      CLEAR: begin
        det_reset = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        det_in_bit = sreg[FRAME_W-1];
        // The detector output in bit slot k reflects bit k-1, so slot 0
        // still shows the cleared detector and is not counted.
        sample_en  = (bit_cnt != '0);
        if (bit_cnt == LAST_BIT) state_nxt = DRAIN;
      end
      DRAIN: begin
        sample_en = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hits_nxt = (sample_en && det_seq_detected && (hits != CNT_MAX))
                    ? hits + CNT_W'(1) : hits;

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sreg          <= '0;
      bit_cnt       <= '0;
      hits          <= '0;
      cur_id        <= '0;
      last_id       <= ID_W'(N_REQ - 1);
      bus.gnt       <= '0;
      bus.done      <= 1'b0;
      bus.done_id   <= '0;
      bus.hit_count <= '0;
    end else begin
      state    <= state_nxt;
      bus.gnt  <= '0;
      bus.done <= 1'b0;
      hits     <= hits_nxt;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            sreg    <= bus.frame_data[int'(win_id)*FRAME_W +: FRAME_W];
            cur_id  <= win_id;
            last_id <= win_id;
            hits    <= '0;
            bit_cnt <= '0;
            // Registered so the grant pulse lines up with CLEAR.
            bus.gnt <= N_REQ'(1) << win_id;
          end
        end
        SHIFT: begin
          sreg    <= sreg << 1;
          bit_cnt <= bit_cnt + BC_W'(1);
        end
        DRAIN: begin
          // hits_nxt already includes the final DRAIN sample.
          bus.done      <= 1'b1;
          bus.done_id   <= cur_id;
          bus.hit_count <= hits_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
Shares one serial sequence_detector instance between N_REQ requesters.
- Each requester submits a FRAME_W-bit frame. The block arbitrates round-robin, clears the detector, then shifts the frame into it MSB-first on in_bit.
- It counts seq_detected pulses produced by the frame and returns the hit count tagged with the requester id.
- It sits between producer blocks and the detector, and drives the detector's clk-domain reset and in_bit.

Parameters:
N_REQ, 2, number of requesters (2..8).
ID_W, 1, requester id width; must satisfy 2^ID_W >= N_REQ.
FRAME_W, 8, bits per frame (>= 2).
CNT_W, 4, hit counter width; counter saturates.

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
req  input  N_REQ  per-requester request; held high with stable data until gnt.
frame_data  input  N_REQ*FRAME_W  requester i frame at [i*FRAME_W +: FRAME_W].
gnt  output  N_REQ  one-hot, one-cycle pulse: frame of that requester accepted.
det_reset  output  1  to detector reset.
det_in_bit  output  1  to detector in_bit.
det_seq_detected  input  1  from detector seq_detected (Moore; valid the cycle after the completing bit is sampled).
busy  output  1  high from CLEAR through DONE.
done  output  1  one-cycle pulse: result valid.
done_id  output  ID_W  requester of the finished frame; held until next done.
hit_count  output  CNT_W  hits in the finished frame; held until next done.

Behaviour:
- Reset (sync):
  - state=IDLE; gnt=0, done=0, busy=0, det_in_bit=0, done_id=0, hit_count=0.
  - RR pointer last_id=N_REQ-1, so requester 0 wins first.
  - det_reset=1 combinationally while reset is high.
- Reset mid-frame aborts immediately. No done, no gnt. The partial count is discarded.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - det_reset=0, det_in_bit=0.
  - If any req: winner = first set req scanning last_id+1, last_id+2, … (mod N_REQ).
  - On that edge: latch winner's frame into shift reg, winner into cur_id and last_id, clear hit counter and bit counter, then go to CLEAR.
  - No req: stay in IDLE.
- CLEAR (1 cycle):
  - gnt[cur_id]=1 (registered pulse), det_reset=1, det_in_bit=0.
  - Next state is SHIFT.
- SHIFT (FRAME_W cycles, bit index k=0..FRAME_W-1):
  - det_in_bit = shift reg MSB; shift left each cycle.
  - At k=FRAME_W-1, go to DRAIN.
- Hit sampling window: SHIFT cycles k>=1 plus the DRAIN cycle, exactly FRAME_W samples.
  - Each sample with det_seq_detected=1 increments the hit counter, saturating at 2^CNT_W-1.
  - det_seq_detected is ignored in IDLE, CLEAR, SHIFT k=0 and DONE.
- DRAIN (1 cycle): det_in_bit=0; final sample taken; go to DONE.
- DONE (1 cycle):
  - done=1; done_id=cur_id and hit_count=counter are registered, visible this cycle, and held afterwards.
  - Next state is IDLE.
- Latency: gnt at cycle t+1 after IDLE sees req at t. done at t+FRAME_W+3. Back-to-back frames restart IDLE→CLEAR, giving a throughput of FRAME_W+4 cycles per frame.
- Requests are sampled only in IDLE. A req still high in the IDLE cycle after DONE is a new request. Requesters drop req the cycle after gnt.
- Changes to frame_data after the latch edge have no effect.
- The detector is always cleared before every frame, so there are no cross-frame pattern overlaps.

Test Plan:
Bench: N_REQ=2, FRAME_W=8, CNT_W=4. The behavioural detector is Moore, overlapping, pattern 1101, sync reset.
1. req[0], frame 8'b1101_1010 → gnt=2'b01 one cycle after req; det_in_bit sequence 1,1,0,1,1,0,1,0; done 11 cycles after req; done_id=0, hit_count=2.
2. req[1], frame 8'b0000_1101 (pattern completes on last bit) → DRAIN sample counted, hit_count=1, done_id=1.
3. Req[0] frame 8'b0000_0110, then req[0] frame 8'b1000_0000 → second result hit_count=0. This proves det_reset pulses in CLEAR and no cross-frame hit.
4. Both req held high continuously → grants alternate 01,10,01,10; each grant spaced 12 cycles; done_id alternates 0,1,0,1.
5. CNT_W=1 override, frame 8'b1101_1010 → hit_count=1 (saturated).
6. reset asserted at SHIFT k=4 → next cycle: state IDLE, busy=0, no done, det_reset=1 during reset. Next req[0] receives the first grant; pointer restored.
